// File: rtl/ins_fetch_if.sv
// Handshake/bus bundle between the fetch stage and its controller:
// run/halt control, program-load port, branch condition and the fetch outputs.
interface ins_fetch_if #(
    parameter int PC_W  = 4,
    parameter int INS_W = 11
);
    logic             run;
    logic             halt_req;
    logic             prog_we;
    logic [PC_W-1:0]  prog_addr;
    logic [INS_W-1:0] prog_data;
    logic             br_cond;
    logic [INS_W-1:0] INS;
    logic [PC_W-1:0]  PC;
    logic             ins_valid;
    logic             running;

    modport master (
        output run, halt_req, prog_we, prog_addr, prog_data, br_cond,
        input  INS, PC, ins_valid, running
    );

    modport slave (
        input  run, halt_req, prog_we, prog_addr, prog_data, br_cond,
        output INS, PC, ins_valid, running
    );
endinterface

// File: rtl/ins_fetch.sv
// Fetch stage: PC, 16-entry program RAM and registered INS feeding the decoder.
// Taken branches squash one slot; the RAM can be loaded while IDLE or HALT.
module ins_fetch #(
    parameter int               PC_W  = 4,
    parameter int               INS_W = 11,
    parameter logic [INS_W-1:0] NOOP  = 11'b01100000000
) (
    input logic        clk,
    input logic        rst,
    ins_fetch_if.slave bus
);
    localparam int DEPTH = 1 << PC_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic             valid_q, valid_d;
    logic             running_q, running_d;

    logic [INS_W-1:0] mem [DEPTH];
    logic             mem_we;
    logic             is_br;
    logic             take;
    logic             squash;
    logic [PC_W-1:0]  br_target;

    assign is_br     = (ins_q[10:8] == 3'b100);
    assign take      = running_q & valid_q & is_br & bus.br_cond;
    assign squash    = take | bus.halt_req;
    assign br_target = ins_q[4 +: PC_W];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = NOOP;
        valid_d = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_we = bus.prog_we;
                if (bus.run) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                ins_d   = squash ? NOOP : mem[pc_q];
                valid_d = ~squash;
                // A halt without a branch keeps PC on the unfetched word so resume refetches it.
                if (take)
                    pc_d = br_target;
                else if (!bus.halt_req)
                    pc_d = pc_q + PC_W'(1);
                if (bus.halt_req)
                    state_d = HALT;
            end
            HALT: begin
                mem_we = bus.prog_we;
                if (bus.run)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ins_q     <= NOOP;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            valid_q   <= valid_d;
            running_q <= running_d;
        end
    end

    // Program RAM is deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    assign bus.INS       = ins_q;
    assign bus.PC        = pc_q;
    assign bus.ins_valid = valid_q;
    assign bus.running   = running_q;
endmodule
